// File: rtl/cdiv_pkg.sv
// Shared types and helpers for the fixed-point complex divider.
// Helpers work on MAXW-bit containers; callers slice to their W.
package cdiv_pkg;

    typedef enum logic [2:0] {IDLE, MUL, PRE, DIV, SAT, DONE} state_t;

    localparam int MAXW = 32;

    // Returns {saturated, value}; value is the signed W-bit result, sign-extended.
    function automatic logic [MAXW:0] sat_w(input logic neg, input logic ovf,
                                            input logic [MAXW-1:0] q, input int w);
        logic [MAXW-1:0] lim;
        lim = MAXW'(1) << (w - 1);
        if (!neg) begin
            if (ovf || q > lim - MAXW'(1)) return {1'b1, lim - MAXW'(1)};
            return {1'b0, q};
        end
        if (ovf || q > lim) return {1'b1, -lim};
        return {1'b0, -q};
    endfunction

    function automatic logic [2*MAXW-1:0] cpack(input logic [MAXW-1:0] re,
                                                input logic [MAXW-1:0] im, input int w);
        logic [MAXW-1:0] m;
        m = (MAXW'(1) << w) - MAXW'(1);
        return ((2*MAXW)'(re & m) << w) | (2*MAXW)'(im & m);
    endfunction

    function automatic logic [MAXW-1:0] cre(input logic [2*MAXW-1:0] x, input int w);
        return MAXW'(x >> w);
    endfunction

    function automatic logic [MAXW-1:0] cim(input logic [2*MAXW-1:0] x, input int w);
        return MAXW'(x) & ((MAXW'(1) << w) - MAXW'(1));
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Iterative restoring unsigned divider, one quotient bit per clock, MSB first.
// Assumes dividend < (divisor << QW) so the quotient fits in QW bits.
module seq_udiv #(
    parameter int DW = 41,
    parameter int VW = 33,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic [QW-1:0] o_quot,
    output logic          o_done
);
    localparam int CNTW = $clog2(QW + 1);

    logic [VW-1:0]   r_rem;
    logic [VW-1:0]   r_div;
    logic [QW-1:0]   r_low;
    logic [CNTW-1:0] r_cnt;
    logic            r_busy;

    logic [VW:0]     w_trial;
    logic [VW:0]     w_diff;
    logic            w_ge;

    // r_low starts as the low dividend bits and fills with quotient bits from the right.
    assign w_trial = {r_rem, r_low[QW-1]};
    assign w_diff  = w_trial - {1'b0, r_div};
    assign w_ge    = (w_trial >= {1'b0, r_div});
    assign o_done  = r_busy && (r_cnt == CNTW'(QW - 1));
    assign o_quot  = r_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_low  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= VW'(i_dividend >> QW);
            r_low  <= i_dividend[QW-1:0];
            r_div  <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_diff[VW-1:0] : w_trial[VW-1:0];
            r_low  <= {r_low[QW-2:0], w_ge};
            r_cnt  <= r_cnt + CNTW'(1);
            if (o_done) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/cdiv_fx_seq.sv
// Fixed-point complex divider Q = A*conj(B)/|B|^2 with valid/ready handshakes.
// Fixed latency of W+3 cycles from accept to out_valid, independent of data.
module cdiv_fx_seq
    import cdiv_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           div_by_zero,
    output logic           overflow
);
    localparam int PW = 2 * W;
    localparam int NW = 2 * W + 1;
    localparam int DW = NW + FRAC;
    localparam int CW = 3 * W + 2;

    state_t r_state, w_next;

    logic signed [W-1:0]  r_ar, r_ai, r_br, r_bi;
    logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ir, r_p_ri;
    logic [NW-1:0]        r_den;
    logic                 r_dz, r_neg_re, r_neg_im, r_ovf_re, r_ovf_im;
    logic [2*W-1:0]       r_result;
    logic                 r_dz_out, r_ovf_out;

    logic [MAXW-1:0]      w_are, w_aim, w_bre, w_bim;
    logic signed [PW-1:0] w_sq_r, w_sq_i;
    logic signed [NW-1:0] w_num_re, w_num_im;
    logic [NW-1:0]        w_mag_re, w_mag_im;
    logic [DW-1:0]        w_n_re, w_n_im;
    logic [W-1:0]         w_q_re, w_q_im;
    logic                 w_done_re, w_done_im;
    logic [MAXW:0]        w_sat_re, w_sat_im;
    logic [2*MAXW-1:0]    w_pack;

    assign w_are = cre((2*MAXW)'(a), W);
    assign w_aim = cim((2*MAXW)'(a), W);
    assign w_bre = cre((2*MAXW)'(b), W);
    assign w_bim = cim((2*MAXW)'(b), W);

    assign w_sq_r = r_br * r_br;
    assign w_sq_i = r_bi * r_bi;

    assign w_num_re = {r_p_rr[PW-1], r_p_rr} + {r_p_ii[PW-1], r_p_ii};
    assign w_num_im = {r_p_ir[PW-1], r_p_ir} - {r_p_ri[PW-1], r_p_ri};
    assign w_mag_re = w_num_re[NW-1] ? NW'(-w_num_re) : w_num_re;
    assign w_mag_im = w_num_im[NW-1] ? NW'(-w_num_im) : w_num_im;
    assign w_n_re   = DW'(w_mag_re) << FRAC;
    assign w_n_im   = DW'(w_mag_im) << FRAC;

    seq_udiv #(.DW(DW), .VW(NW), .QW(W)) u_div_re (
        .clk(clk), .rst(rst), .i_start(r_state == PRE), .i_dividend(w_n_re),
        .i_divisor(r_den), .o_quot(w_q_re), .o_done(w_done_re)
    );

    seq_udiv #(.DW(DW), .VW(NW), .QW(W)) u_div_im (
        .clk(clk), .rst(rst), .i_start(r_state == PRE), .i_dividend(w_n_im),
        .i_divisor(r_den), .o_quot(w_q_im), .o_done(w_done_im)
    );

    assign w_sat_re = sat_w(r_neg_re, r_ovf_re, MAXW'(w_q_re), W);
    assign w_sat_im = sat_w(r_neg_im, r_ovf_im, MAXW'(w_q_im), W);
    assign w_pack   = cpack(w_sat_re[MAXW-1:0], w_sat_im[MAXW-1:0], W);

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign result      = r_result;
    assign div_by_zero = r_dz_out;
    assign overflow    = r_ovf_out;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = MUL;
            MUL:     w_next = PRE;
            PRE:     w_next = DIV;
            DIV:     if (w_done_re && w_done_im) w_next = SAT;
            SAT:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ar <= '0; r_ai <= '0; r_br <= '0; r_bi <= '0;
            r_p_rr <= '0; r_p_ii <= '0; r_p_ir <= '0; r_p_ri <= '0;
            r_den <= '0;
            r_dz <= 1'b0; r_neg_re <= 1'b0; r_neg_im <= 1'b0;
            r_ovf_re <= 1'b0; r_ovf_im <= 1'b0;
            r_result <= '0; r_dz_out <= 1'b0; r_ovf_out <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (in_valid) begin
                    r_ar <= w_are[W-1:0];
                    r_ai <= w_aim[W-1:0];
                    r_br <= w_bre[W-1:0];
                    r_bi <= w_bim[W-1:0];
                end
                MUL: begin
                    r_p_rr <= r_ar * r_br;
                    r_p_ii <= r_ai * r_bi;
                    r_p_ir <= r_ai * r_br;
                    r_p_ri <= r_ar * r_bi;
                    r_den  <= NW'($unsigned(w_sq_r)) + NW'($unsigned(w_sq_i));
                end
                PRE: begin
                    r_dz     <= (r_den == '0);
                    r_neg_re <= w_num_re[NW-1];
                    r_neg_im <= w_num_im[NW-1];
                    // Quotient would not fit in W bits; the divider result is then ignored.
                    r_ovf_re <= (CW'(w_n_re) >= (CW'(r_den) << W));
                    r_ovf_im <= (CW'(w_n_im) >= (CW'(r_den) << W));
                end
                SAT: begin
                    if (r_dz) begin
                        r_result  <= '0;
                        r_dz_out  <= 1'b1;
                        r_ovf_out <= 1'b0;
                    end else begin
                        r_result  <= w_pack[2*W-1:0];
                        r_dz_out  <= 1'b0;
                        r_ovf_out <= w_sat_re[MAXW] | w_sat_im[MAXW];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdiv_fx_seq.sv
// Bench for cdiv_fx_seq at W=16, FRAC=8: vector table, random ops against a
// reference model, plus backpressure and mid-operation reset sequences.
module tb_cdiv_fx_seq;
    localparam int W    = 16;
    localparam int FRAC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        div_by_zero;
    logic        overflow;

    always #5 clk = ~clk;

    cdiv_fx_seq #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        logic        ov;
        string       nm;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        logic        ov;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] mcomp(input longint n, input longint den);
        longint      mag, q;
        logic        neg, ovf;
        logic [15:0] v;
        neg = (n < 0);
        mag = neg ? -n : n;
        ovf = (mag * 256) >= (den * 65536);
        q   = ovf ? 0 : (mag * 256) / den;
        if (!neg) begin
            if (ovf || q > 32767) return {1'b1, 16'h7FFF};
            v = q[15:0];
            return {1'b0, v};
        end
        if (ovf || q > 32768) return {1'b1, 16'h8000};
        v = 16'(-q);
        return {1'b0, v};
    endfunction

    // {div_by_zero, overflow, result}
    function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv);
        longint      ar, ai, br, bi, den;
        logic [16:0] cr, ci;
        ar  = longint'($signed(av[31:16]));
        ai  = longint'($signed(av[15:0]));
        br  = longint'($signed(bv[31:16]));
        bi  = longint'($signed(bv[15:0]));
        den = br * br + bi * bi;
        if (den == 0) return {1'b1, 1'b0, 32'h0};
        cr = mcomp(ar * br + ai * bi, den);
        ci = mcomp(ai * br - ar * bi, den);
        return {1'b0, cr[16] | ci[16], cr[15:0], ci[15:0]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", 64'(result), 64'hDEAD);
            end else begin
                e = sbq.pop_front();
                chk(e.nm, 64'({div_by_zero, overflow, result}), 64'({e.dz, e.ov, e.res}));
            end
        end
    end

    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         input bit push, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        if (push) sbq.push_back(e);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_done(input string nm);
        int cyc;
        cyc = 0;
        @(negedge clk);
        chk({nm, "_busy"}, 64'({in_ready, out_valid}), 64'(0));
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 60);
        chk({nm, "_latency"}, 64'(cyc), 64'(W + 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[7];
        exp_t        e;
        logic [31:0] av, bv;
        logic [33:0] m;

        tv[0] = '{32'h0200_0000, 32'h0100_0000, 32'h0200_0000, 1'b0, 1'b0, "div_2_by_1"};
        tv[1] = '{32'h0100_0100, 32'h0100_FF00, 32'h0000_0100, 1'b0, 1'b0, "one_plus_j_over_one_minus_j"};
        tv[2] = '{32'h0100_0000, 32'h0300_0000, 32'h0055_0000, 1'b0, 1'b0, "trunc_pos"};
        tv[3] = '{32'hFF00_0000, 32'h0300_0000, 32'hFFAB_0000, 1'b0, 1'b0, "trunc_neg"};
        tv[4] = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, "div_by_zero"};
        tv[5] = '{32'h7F00_0000, 32'h0001_0000, 32'h7FFF_0000, 1'b0, 1'b1, "sat_pos"};
        tv[6] = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b1, "sat_neg"};

        #12;
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_outputs", 64'({div_by_zero, overflow, result}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            e = '{tv[i].res, tv[i].dz, tv[i].ov, tv[i].nm};
            do_op(tv[i].a, tv[i].b, 1'b1, e);
            wait_done(tv[i].nm);
        end

        // Backpressure: result must hold while out_ready is low.
        @(posedge clk);
        #2 out_ready = 1'b0;
        e = '{tv[0].res, tv[0].dz, tv[0].ov, "hold_release"};
        do_op(tv[0].a, tv[0].b, 1'b1, e);
        wait_done("hold");
        for (int i = 0; i < 5; i++) begin
            chk("hold_state", 64'({out_valid, in_ready}), 64'(2'b10));
            chk("hold_result", 64'(result), 64'(32'h0200_0000));
            @(negedge clk);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_released_idle", 64'({out_valid, in_ready}), 64'(2'b01));

        // Abort in DIV, then a clean operation.
        e = '{32'h0, 1'b0, 1'b0, "aborted"};
        do_op(tv[2].a, tv[2].b, 1'b0, e);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_handshake", 64'({out_valid, in_ready}), 64'(2'b01));
        chk("abort_outputs", 64'({div_by_zero, overflow, result}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        e = '{tv[3].res, tv[3].dz, tv[3].ov, "after_abort"};
        do_op(tv[3].a, tv[3].b, 1'b1, e);
        wait_done("after_abort");

        for (int i = 0; i < 12; i++) begin
            av = $urandom;
            bv = $urandom;
            if (i % 2 == 1) av = {{4{av[31]}}, av[31:20], {4{av[15]}}, av[15:4]};
            if (i % 4 == 2) bv = {{8{bv[31]}}, bv[31:24], {8{bv[15]}}, bv[15:8]};
            m = model(av, bv);
            e = '{m[31:0], m[33], m[32], $sformatf("rand%0d", i)};
            do_op(av, bv, 1'b1, e);
            wait_done($sformatf("rand%0d", i));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
